// File: rtl/riscv_retire_trace_fifo.sv
// riscv_retire_trace_fifo
// Turns each core retire event into a sequence-numbered trace record and
// buffers it in a DEPTH-entry first-word-fall-through FIFO. A new record
// that finds the FIFO full is dropped and counted. The sequence numbers in
// the output stream show where records were lost.

module riscv_retire_trace_fifo #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 16,
    parameter int SEQW  = 32
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    // retire port from the core
    input  logic                     update_i,
    input  logic [XLEN-1:0]          pc_i,
    input  logic [XLEN-1:0]          instr_i,
    input  logic [4:0]               reg_addr_i,
    input  logic [XLEN-1:0]          reg_data_i,
    input  logic [XLEN-1:0]          mem_addr_i,
    input  logic [XLEN-1:0]          mem_data_i,
    input  logic                     mem_wrt_i,
    input  logic                     flush_i,
    // trace stream
    output logic                     t_valid_o,
    input  logic                     t_ready_i,
    output logic [SEQW-1:0]          t_seq_o,
    output logic [XLEN-1:0]          t_pc_o,
    output logic [XLEN-1:0]          t_instr_o,
    output logic [4:0]               t_reg_addr_o,
    output logic [XLEN-1:0]          t_reg_data_o,
    output logic [XLEN-1:0]          t_mem_addr_o,
    output logic [XLEN-1:0]          t_mem_data_o,
    output logic                     t_mem_wrt_o,
    // status
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     overflow_o,
    output logic [15:0]              drop_cnt_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef struct packed {
        logic [SEQW-1:0] seq;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic [4:0]      reg_addr;
        logic [XLEN-1:0] reg_data;
        logic [XLEN-1:0] mem_addr;
        logic [XLEN-1:0] mem_data;
        logic            mem_wrt;
    } rec_t;

    // Storage is not reset. The head is masked to zero while the FIFO is
    // empty, so stale entries are never visible.
    rec_t            mem_q [DEPTH];

    // Pointers carry an extra MSB wrap flag. This separates full from empty
    // when the index bits are equal.
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [SEQW-1:0] seq_q, seq_d;
    logic            ovf_q, ovf_d;
    logic [15:0]     drop_q, drop_d;

    logic            empty, full, pop, push, drop;
    rec_t            rec_in, head;

    // Occupancy flags and handshake qualification
    always_comb begin
        empty = (wr_ptr_q == rd_ptr_q);
        full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop   = !empty && t_ready_i;
        // A full FIFO still accepts a record when the head leaves in the same cycle.
        push  = update_i && (!full || pop);
        drop  = update_i && !push;
    end

    // Assemble the incoming record. It is tagged with the counter value
    // taken before the increment.
    always_comb begin
        rec_in          = '0;
        rec_in.seq      = seq_q;
        rec_in.pc       = pc_i;
        rec_in.instr    = instr_i;
        rec_in.reg_addr = reg_addr_i;
        rec_in.reg_data = reg_data_i;
        rec_in.mem_addr = mem_addr_i;
        rec_in.mem_data = mem_data_i;
        rec_in.mem_wrt  = mem_wrt_i;
    end

    // Next-state logic. Flush wins over push, pop and drop accounting, but
    // the sequence counter keeps running across it.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        drop_d   = drop_q;
        seq_d    = update_i ? seq_q + 1'b1 : seq_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            ovf_d    = 1'b0;
            drop_d   = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (drop) begin
                ovf_d = 1'b1;
                if (drop_q != 16'hFFFF) drop_d = drop_q + 1'b1;
            end
        end
    end

    // Control and status registers
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            seq_q    <= '0;
            ovf_q    <= 1'b0;
            drop_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            seq_q    <= seq_d;
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
        end
    end

    // Record storage write. A flushed push never lands.
    always_ff @(posedge clk_i) begin
        if (push && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= rec_in;
    end

    // Fall-through head, zeroed while empty
    always_comb begin
        head = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    end

    assign t_valid_o    = !empty;
    assign t_seq_o      = head.seq;
    assign t_pc_o       = head.pc;
    assign t_instr_o    = head.instr;
    assign t_reg_addr_o = head.reg_addr;
    assign t_reg_data_o = head.reg_data;
    assign t_mem_addr_o = head.mem_addr;
    assign t_mem_data_o = head.mem_data;
    assign t_mem_wrt_o  = head.mem_wrt;

    assign level_o      = wr_ptr_q - rd_ptr_q;
    assign overflow_o   = ovf_q;
    assign drop_cnt_o   = drop_q;

endmodule
